// File: rtl/data_memory_responder_pkg.sv
// Shared constants and types for the MEM-stage responder: funct3 codes,
// IO register addresses, FSM encoding and the latched request record.
package data_memory_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [XLEN-1:0] IO_IN_ADDR_DEF  = 32'h8000_0000;
    localparam logic [XLEN-1:0] IO_OUT_ADDR_DEF = 32'h8000_0004;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_e;

    typedef struct packed {
        logic            write;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/data_memory_responder_lsu_lane_aligner.sv
// Combinational byte-lane logic: store enables/replication, load extraction
// with sign/zero extension, and the misaligned-or-illegal-funct3 flag.
module lsu_lane_aligner
    import data_memory_responder_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic            is_write,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] raw_word,
    input  logic [XLEN-1:0] wdata,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] store_word,
    output logic [XLEN-1:0] load_value,
    output logic            is_word,
    output logic            bad
);

    logic        sz_byte, sz_half, illegal, misaligned;
    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        sz_byte = (funct3 == F3_LB) || (!is_write && funct3 == F3_LBU);
        sz_half = (funct3 == F3_LH) || (!is_write && funct3 == F3_LHU);
        is_word = (funct3 == F3_LW);
        illegal = !(sz_byte || sz_half || is_word);
        misaligned = (sz_half && addr_lo[0]) || (is_word && addr_lo != 2'b00);
        bad = illegal || misaligned;

        byte_en    = 4'b0000;
        store_word = wdata;
        if (sz_byte) begin
            byte_en    = 4'b0001 << addr_lo;
            store_word = {4{wdata[7:0]}};
        end else if (sz_half) begin
            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            store_word = {2{wdata[15:0]}};
        end else if (is_word) begin
            byte_en    = 4'b1111;
        end

        lb = raw_word[8*addr_lo +: 8];
        lh = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        case (funct3)
            F3_LB:   load_value = {{24{lb[7]}}, lb};
            F3_LBU:  load_value = {24'd0, lb};
            F3_LH:   load_value = {{16{lh[15]}}, lh};
            F3_LHU:  load_value = {16'd0, lh};
            default: load_value = raw_word;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage responder: one outstanding load/store at a time, served from a
// word RAM or two IO registers, answered after a programmable wait.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int              MEM_WORDS   = 1024,
    parameter int              WAIT_CYCLES = 1,
    parameter logic [XLEN-1:0] IO_IN_ADDR  = IO_IN_ADDR_DEF,
    parameter logic [XLEN-1:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    input  logic [XLEN-1:0] io_input_bus,
    output logic [XLEN-1:0] io_output_bus
);

    localparam int AW = $clog2(MEM_WORDS);

    state_e          state_q, state_d;
    mem_req_t        req_q, req_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_error_q, resp_error_d;
    logic [XLEN-1:0] io_out_q, io_out_d;
    logic [XLEN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [AW-1:0]   ram_idx;
    logic            io_in_hit, io_out_hit, in_range, err, mem_we;
    logic [XLEN-1:0] raw_word, store_word, load_value;
    logic [3:0]      byte_en;
    logic            is_word, lane_bad;

    assign ram_idx    = req_q.addr[AW+1:2];
    assign io_in_hit  = (req_q.addr == IO_IN_ADDR);
    assign io_out_hit = (req_q.addr == IO_OUT_ADDR);
    assign in_range   = (req_q.addr[XLEN-1:AW+2] == '0);
    assign raw_word   = io_in_hit ? sync2_q : (io_out_hit ? io_out_q : mem[ram_idx]);

    lsu_lane_aligner u_aligner (
        .funct3     (req_q.funct3),
        .is_write   (req_q.write),
        .addr_lo    (req_q.addr[1:0]),
        .raw_word   (raw_word),
        .wdata      (req_q.wdata),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_value (load_value),
        .is_word    (is_word),
        .bad        (lane_bad)
    );

    // IO registers only take full aligned words; input register is read-only.
    assign err = lane_bad
               || ((io_in_hit || io_out_hit) && !is_word)
               || (req_q.write && io_in_hit)
               || (!io_in_hit && !io_out_hit && !in_range);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        io_out_d     = io_out_q;
        sync1_d      = io_input_bus;
        sync2_d      = sync1_q;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d     = S_WAIT;
                req_ready_d = 1'b0;
                req_d       = '{write: req_write, funct3: req_funct3,
                                addr: req_addr, wdata: req_wdata};
                cnt_d       = 4'(WAIT_CYCLES);
            end
            S_WAIT: if (cnt_q == 4'd0) begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = err;
                resp_rdata_d = (err || req_q.write) ? '0 : load_value;
                if (req_q.write && !err) begin
                    if (io_out_hit) io_out_d = store_word;
                    else            mem_we   = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            S_RESP: if (resp_ready) begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            io_out_q     <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            io_out_q     <= io_out_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[ram_idx][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_error    = resp_error_q;
    assign io_output_bus = io_out_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed-vector scoreboard bench: stimulus pushes expected responses,
// an independent monitor checks every presented response and its latency.
module tb_data_memory_responder;

    localparam int WAITC = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] io_input_bus = '0;
    logic [31:0] io_output_bus;

    data_memory_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(WAITC)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .io_input_bus(io_input_bus), .io_output_bus(io_output_bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    bit   seen = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle the response is presented (covers hold
    // stability), checks latency on first sight, pops on handshake.
    always @(negedge clock) begin
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_resp: got rdata %h with empty scoreboard", resp_rdata);
            end else begin
                if (!seen) begin
                    seen = 1;
                    check("latency", 32'(cyc - sb[0].acc), 32'(WAITC + 1));
                end
                check("rdata", resp_rdata, sb[0].rd);
                check("error", {31'd0, resp_error}, {31'd0, sb[0].err});
                if (resp_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
        int guard = 0;
        do begin
            @(posedge clock); #1;
            guard++;
        end while ((!req_ready || sb.size() != 0) && guard < 200);
        if (guard >= 200) begin
            n_checks++;
            n_err++;
            $display("FAIL issue_timeout: req_ready %b pending %0d expected idle", req_ready, sb.size());
        end
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        sb.push_back('{erd, eerr, cyc});
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        io_input_bus = 32'h0000_1234;
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", {31'd0, resp_error}, 32'd0);
        check("rst_io_out", io_output_bus, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // word store/load
        issue(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        // byte lanes
        issue(1, 3'd2, 32'h20, 32'h11223344, 32'h0, 0);
        issue(1, 3'd0, 32'h21, 32'h00000080, 32'h0, 0);
        issue(0, 3'd0, 32'h21, 32'h0, 32'hFFFFFF80, 0);
        issue(0, 3'd4, 32'h21, 32'h0, 32'h00000080, 0);
        issue(0, 3'd2, 32'h20, 32'h0, 32'h11228044, 0);
        // halfword lanes
        issue(0, 3'd1, 32'h22, 32'h0, 32'h00001122, 0);
        issue(1, 3'd1, 32'h22, 32'h00008001, 32'h0, 0);
        issue(0, 3'd1, 32'h22, 32'h0, 32'hFFFF8001, 0);
        issue(0, 3'd5, 32'h22, 32'h0, 32'h00008001, 0);
        issue(0, 3'd2, 32'h20, 32'h0, 32'h80018044, 0);
        // errors leave memory untouched
        issue(1, 3'd2, 32'h04, 32'h01020304, 32'h0, 0);
        issue(0, 3'd1, 32'h03, 32'h0, 32'h0, 1);
        issue(1, 3'd2, 32'h06, 32'hCAFEF00D, 32'h0, 1);
        issue(1, 3'd1, 32'h05, 32'hFFFF, 32'h0, 1);
        issue(0, 3'd2, 32'h04, 32'h0, 32'h01020304, 0);
        issue(0, 3'd3, 32'h04, 32'h0, 32'h0, 1);
        issue(1, 3'd4, 32'h04, 32'h0, 32'h0, 1);
        issue(1, 3'd2, 32'hFFC, 32'hA1B2C3D4, 32'h0, 0);
        issue(0, 3'd2, 32'hFFC, 32'h0, 32'hA1B2C3D4, 0);
        issue(0, 3'd2, 32'h1000, 32'h0, 32'h0, 1);
        // IO registers
        issue(1, 3'd2, 32'h8000_0004, 32'h000000A5, 32'h0, 0);
        drain();
        check("io_out_after_sw", io_output_bus, 32'h000000A5);
        issue(0, 3'd2, 32'h8000_0004, 32'h0, 32'h000000A5, 0);
        issue(0, 3'd2, 32'h8000_0000, 32'h0, 32'h00001234, 0);
        issue(0, 3'd0, 32'h8000_0004, 32'h0, 32'h0, 1);
        issue(1, 3'd2, 32'h8000_0000, 32'h5, 32'h0, 1);
        drain();
        check("io_out_unchanged", io_output_bus, 32'h000000A5);

        // back-pressure hold
        resp_ready = 1'b0;
        issue(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        begin
            int g = 0;
            while (!resp_valid && g < 50) begin
                @(posedge clock); #1;
                g++;
            end
        end
        repeat (5) begin
            @(posedge clock); #1;
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check("release_req_ready", {31'd0, req_ready}, 32'd1);
        check("release_resp_valid", {31'd0, resp_valid}, 32'd0);

        // reset during WAIT drops the store and the pending response
        issue(1, 3'd2, 32'h40, 32'h11111111, 32'h0, 0);
        issue(1, 3'd2, 32'h40, 32'h00000055, 32'h0, 0);
        #4;
        reset = 1'b1;
        #1;
        sb.delete();
        seen = 0;
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("arst_resp_rdata", resp_rdata, 32'd0);
        check("arst_resp_error", {31'd0, resp_error}, 32'd0);
        check("arst_io_out", io_output_bus, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        issue(0, 3'd2, 32'h40, 32'h0, 32'h11111111, 0);
        issue(0, 3'd2, 32'h8000_0004, 32'h0, 32'h0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
